// File: rtl/phase_accumulator_pkg.sv
// Shared S3.4 fixed-point constants, phase type and FSM state encoding for the
// phase generator and any later phase-rotation stages.
package phase_accumulator_pkg;

    localparam int unsigned TOTAL_WIDTH = 8;
    localparam int unsigned FRAC_WIDTH  = 4;
    localparam int unsigned CNT_W       = 8;

    // round(3.14159 * 2^FRAC_WIDTH) == 50 for S3.4
    localparam int PI_FX     = (314159 * (1 << FRAC_WIDTH) + 50000) / 100000;
    localparam int TWO_PI_FX = 2 * PI_FX;

    typedef logic signed [TOTAL_WIDTH-1:0] phase_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/phase_accumulator_if.sv
// Valid/ready sample stream carrying S3.4 phase values to the sine stage.
interface phase_accumulator_if;
    import phase_accumulator_pkg::*;

    phase_t phase_out;
    logic   out_valid;
    logic   out_ready;

    modport master (output phase_out, output out_valid, input out_ready);
    modport slave  (input phase_out, input out_valid, output out_ready);

endinterface

// File: rtl/phase_accumulator_wrap.sv
// Combinational wrapped phase addition: (a + b) folded back into [-PI_FX, PI_FX).
// A single correction is enough when both operands are range-checked upstream.
module phase_accumulator_wrap
    import phase_accumulator_pkg::*;
(
    input  phase_t a,
    input  phase_t b,
    output phase_t sum
);

    localparam int unsigned SW = TOTAL_WIDTH + 2;

    localparam logic signed [SW-1:0] PiW    = SW'(PI_FX);
    localparam logic signed [SW-1:0] TwoPiW = SW'(TWO_PI_FX);

    logic signed [SW-1:0] raw;
    logic signed [SW-1:0] fixed;

    always_comb begin
        raw   = $signed({{2{a[TOTAL_WIDTH-1]}}, a}) + $signed({{2{b[TOTAL_WIDTH-1]}}, b});
        fixed = raw;
        if (raw >= PiW) begin
            fixed = raw - TwoPiW;
        end else if (raw < -PiW) begin
            fixed = raw + TwoPiW;
        end
        sum = phase_t'(fixed);
    end

endmodule

// File: rtl/phase_accumulator.sv
// Burst phase generator: emits num_samples wrapped S3.4 phases init + n*step over a
// valid/ready stream, then pulses done. Out-of-range start requests pulse err.
module phase_accumulator
    import phase_accumulator_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  phase_t                  phase_init,
    input  phase_t                  phase_step,
    input  logic [CNT_W-1:0]        num_samples,
    phase_accumulator_if.master     bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam phase_t PiP = phase_t'(PI_FX);

    state_e           state_q, state_d;
    phase_t           phase_q;
    phase_t           step_q;
    phase_t           phase_nxt;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic inputs_ok;
    logic start_idle;
    logic start_ok;
    logic hs;
    logic last;

    // Step may equal +PI_FX; the starting phase may not.
    assign inputs_ok  = (phase_init >= -PiP) && (phase_init < PiP) &&
                        (phase_step >= -PiP) && (phase_step <= PiP);
    assign start_idle = start && (state_q == StIdle);
    assign start_ok   = start_idle && inputs_ok;
    assign hs         = (state_q == StRun) && bus.out_ready;
    assign last       = (cnt_q == num_q - CNT_W'(1));

    phase_accumulator_wrap u_wrap (
        .a   (phase_q),
        .b   (step_q),
        .sum (phase_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = (num_samples == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (hs && last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            step_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= start_idle && !inputs_ok;
            if (start_ok) begin
                phase_q <= phase_init;
                step_q  <= phase_step;
                num_q   <= num_samples;
                cnt_q   <= '0;
            end else if (hs) begin
                phase_q <= phase_nxt;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.phase_out = phase_q;
        bus.out_valid = (state_q == StRun);
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
        err           = err_q;
    end

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed and randomized bursts against a closed-form modular reference:
// sample k = ((init + k*step + PI) mod 2PI) - PI.
module tb_phase_accumulator;
    import phase_accumulator_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    phase_t           phase_init = '0;
    phase_t           phase_step = '0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             busy, done, err;

    int checks   = 0;
    int failures = 0;

    phase_accumulator_if bus ();

    phase_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .phase_init  (phase_init),
        .phase_step  (phase_step),
        .num_samples (num_samples),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic int model(input int init, input int step, input int k);
        int v;
        v = init + k * step + PI_FX;
        v = ((v % TWO_PI_FX) + TWO_PI_FX) % TWO_PI_FX;
        return v - PI_FX;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one accepted burst. Ready is dropped for stall_n cycles while sample stall_k is
    // presented, otherwise randomly with probability stall_pct. Returns cycles spent in RUN.
    task automatic burst(input int init, input int step, input int num, input int stall_pct,
                         input int stall_k, input int stall_n, input bit poke_start,
                         output int cycles);
        int k;
        int stalls;
        bit rdy;
        k = 0;
        stalls = 0;
        cycles = 0;
        @(negedge clk);
        phase_init  = phase_t'(init);
        phase_step  = phase_t'(step);
        num_samples = CNT_W'(num);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < num && cycles < 2000) begin
            if (k == stall_k && stalls < stall_n) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(0, 99) >= stall_pct);
            end
            bus.out_ready = rdy;
            check("run_valid", int'(bus.out_valid), 1);
            check("run_phase", int'($signed(bus.phase_out)), model(init, step, k));
            check("run_busy", int'(busy), 1);
            check("run_done", int'(done), 0);
            check("run_err", int'(err), 0);
            if (poke_start) begin
                start       = 1'($urandom_range(0, 1));
                phase_init  = phase_t'($urandom_range(0, 255));
                phase_step  = phase_t'($urandom_range(0, 255));
                num_samples = CNT_W'($urandom_range(0, 255));
            end
            if (rdy) k++;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("burst_timeout", int'(cycles < 2000), 1);
        check("done_pulse", int'(done), 1);
        check("done_valid", int'(bus.out_valid), 0);
        check("done_busy", int'(busy), 1);
        @(negedge clk);
        check("after_done", int'(done), 0);
        check("after_busy", int'(busy), 0);
        bus.out_ready = 1'b1;
    endtask

    task automatic reject(input int init, input int step);
        @(negedge clk);
        phase_init  = phase_t'(init);
        phase_step  = phase_t'(step);
        num_samples = CNT_W'(4);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rej_err", int'(err), 1);
        check("rej_valid", int'(bus.out_valid), 0);
        check("rej_busy", int'(busy), 0);
        @(negedge clk);
        check("rej_err_clr", int'(err), 0);
        check("rej_idle", int'(busy), 0);
    endtask

    initial begin
        int cyc;
        int init, step, num;
        bus.out_ready = 1'b1;

        #12;
        check("rst_phase", int'($signed(bus.phase_out)), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Consecutive samples 0,16,32,48,-36,-20,-4,12 with ready held high
        burst(0, 16, 8, 0, -1, 0, 1'b0, cyc);
        check("s1_cycles", cyc, 8);
        burst(0, -16, 5, 0, -1, 0, 1'b0, cyc);
        check("s2_cycles", cyc, 5);
        burst(-50, 50, 4, 0, -1, 0, 1'b0, cyc);
        check("s3_cycles", cyc, 4);

        // Backpressure while the second sample is presented delays done by 3
        burst(0, 16, 8, 0, 1, 3, 1'b0, cyc);
        check("s4_cycles", cyc, 11);

        reject(0, 60);
        reject(50, 16);
        reject(-51, 0);
        reject(0, -51);

        // Empty burst: done on the cycle after start, never valid
        @(negedge clk);
        phase_init  = '0;
        phase_step  = phase_t'(16);
        num_samples = '0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_done", int'(done), 1);
        check("empty_valid", int'(bus.out_valid), 0);
        check("empty_err", int'(err), 0);
        @(negedge clk);
        check("empty_done_clr", int'(done), 0);
        check("empty_busy", int'(busy), 0);

        // Reset after the third sample of a 0/16/8 burst
        @(negedge clk);
        phase_init  = '0;
        phase_step  = phase_t'(16);
        num_samples = CNT_W'(8);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_phase", int'($signed(bus.phase_out)), 48);
        rst_n = 1'b0;
        #1;
        check("mid_rst_phase", int'($signed(bus.phase_out)), 0);
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", int'(done), 0);
        check("post_rst_busy", int'(busy), 0);
        burst(0, 16, 8, 0, -1, 0, 1'b0, cyc);
        check("rerun_cycles", cyc, 8);

        // Random in-range bursts with random backpressure and ignored mid-burst starts
        for (int i = 0; i < 25; i++) begin
            init = $urandom_range(0, 99) - 50;
            step = $urandom_range(0, 100) - 50;
            num  = $urandom_range(1, 12);
            burst(init, step, num, 30, -1, 0, 1'b1, cyc);
            check("rand_cycles_min", int'(cyc >= num), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/phase_accumulator.md
Name: phase_accumulator

Overview:
Sequential phase generator sitting directly upstream of the combinational sine approximation stage. It produces a stream of S3.4 phase samples, x[n] = wrap(init + n*step), kept within [-PI_FX, PI_FX). Samples are delivered over a valid/ready handshake, so the sine stage input always lies inside its characterised range. One start pulse runs a burst of NUM samples, then reports done.

Parameters:
TOTAL_WIDTH, from fixed_point_params.vh (8), total S3.4 word width.
FRAC_WIDTH, from fixed_point_params.vh (4), fractional bits.
PI_FX, 50, pi in S3.4 (round(3.14159*16)).
CNT_W, 8, width of sample counter and num_samples.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a burst; sampled only in IDLE
phase_init  in  TOTAL_WIDTH  signed starting phase; valid range [-PI_FX, PI_FX)
phase_step  in  TOTAL_WIDTH  signed increment per sample; valid range [-PI_FX, PI_FX]
num_samples  in  CNT_W  number of samples in the burst (unsigned)
phase_out  out  TOTAL_WIDTH  signed current phase sample, S3.4
out_valid  out  1  phase_out holds a valid sample
out_ready  in  1  downstream accepts the sample
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at burst completion
err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (async, rst_n=0): state=IDLE; phase_out=0, out_valid=0, busy=0, done=0, err=0; counter=0. Applies immediately mid-burst; no partial completion, no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, phase_init outside [-PI_FX, PI_FX) or phase_step outside [-PI_FX, PI_FX]: err=1 for one cycle; stay in IDLE.
- IDLE, start=1, inputs in range, num_samples=0: go to DONE; no out_valid.
- IDLE, start=1, inputs in range, num_samples>0: latch step and num_samples, set phase_out=phase_init, counter=0; go to RUN.
- Latency: out_valid rises on the cycle after start is sampled.
- RUN:
  - out_valid=1.
  - Handshake occurs on a cycle with out_valid & out_ready.
  - On a handshake: counter+1, phase_out <= wrap(phase_out + step).
  - On the handshake where counter = num_samples-1: go to DONE; out_valid falls on the next cycle.
  - Without a handshake, phase_out and out_valid hold stable (AXI-style; valid never drops before acceptance).
- DONE: done=1 and out_valid=0 for exactly one cycle, then IDLE.
- start outside IDLE: ignored, no err. Inputs are latched only at start; later changes have no effect.
- Wrap arithmetic:
  - Sum at TOTAL_WIDTH+2 bits, sign-extended.
  - If sum >= PI_FX, subtract 2*PI_FX.
  - If sum < -PI_FX, add 2*PI_FX.
  - One correction suffices given the input range checks. The result always lies in [-PI_FX, PI_FX); truncate to TOTAL_WIDTH.
  - Exactly PI_FX maps to -PI_FX.
- busy=1 in RUN and DONE.

Decomposition:
- Add PI_FX and TWO_PI_FX (2*PI_FX) macros to fixed_point_params.vh, alongside TOTAL_WIDTH and FRAC_WIDTH; the sine stage and this block share them.
- One combinational sub-module, phase_wrap(a, b) -> wrapped sum, is natural. It is reusable by any later phase-rotation stage.
- The FSM, counter and handshake stay in phase_accumulator.

Test Plan:
1. init=0, step=16, num=8, out_ready held 1 -> phase_out sequence 0,16,32,48,-36,-20,-4,12 on consecutive cycles. done pulses on the cycle after the 8th handshake; busy falls after that.
2. init=0, step=-16, num=5, out_ready=1 -> 0,-16,-32,-48,36 (-64+100).
3. Boundary: init=-50, step=50, num=4 -> -50,0,-50,0 (50 wraps to -50).
4. Backpressure: run scenario 1 with out_ready=0 for 3 cycles after the 2nd sample. phase_out must hold 16 with out_valid=1 for all 3 cycles; the sequence then resumes unchanged and done is delayed 3 cycles.
5. Rejection and empty burst:
   - step=60 -> err pulse, no out_valid, stays IDLE.
   - step=16, num=0 -> done pulse on the cycle after start, no out_valid.
6. Reset mid-burst: assert rst_n=0 after the 3rd sample of scenario 1. Outputs go to 0 immediately with no done pulse. A subsequent start reproduces the full sequence from 0.
